if_fetch_stage: RTL



---
 rtl/mips32_pkg.sv | 18 +
 rtl/fetch_redirect_mux.sv | 14 +
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline: fetch FSM encoding and architectural constants.
package mips32_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] MIPS_NOP      = 32'h00000000;  // sll $0,$0,0
    localparam logic [31:0] MIPS_RESET_PC = 32'h00000000;

    // Sequential PC advance; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Merges branch and jump redirect requests into one redirect and target; branch has priority.
module fetch_redirect_mux (
    input  logic        i_branchTaken,
    input  logic [31:0] i_branchTarget,
    input  logic        i_jump,
    input  logic [31:0] i_jumpTarget,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    assign o_redirect = i_branchTaken | i_jump;
    assign o_target   = i_branchTaken ? i_branchTarget : i_jumpTarget;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack handshake and feeds a
// one-entry slot into IF/ID, discarding wrong-path data after redirects.
module if_fetch_stage
    import mips32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
    parameter logic [31:0] NOP_INST = MIPS_NOP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branchTaken,
    input  logic [31:0] i_branchTarget,
    input  logic        i_jump,
    input  logic [31:0] i_jumpTarget,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    output logic [31:0] o_pcOut,
    output logic [31:0] o_instOut,
    output logic        o_validOut
);

    fetch_state_t r_state;
    logic [31:0]  r_addr;
    logic [31:0]  r_pc;
    logic [31:0]  r_inst;
    logic         r_valid;
    logic [31:0]  r_holdInst;
    logic [31:0]  r_holdPc;
    logic [31:0]  r_savedTarget;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_accept;
    logic [31:0]  w_addrNext;

    fetch_redirect_mux u_redirect_mux (
        .i_branchTaken (i_branchTaken),
        .i_branchTarget(i_branchTarget),
        .i_jump        (i_jump),
        .i_jumpTarget  (i_jumpTarget),
        .o_redirect    (w_redirect),
        .o_target      (w_target)
    );

    assign w_accept   = !r_valid || !i_stall;
    assign w_addrNext = next_pc(r_addr);

    // Request is live in FETCH and DRAIN; HOLD parks the fetch until the slot frees.
    assign o_imemReq  = !i_rst && (r_state != HOLD);
    assign o_imemAddr = r_addr;
    assign o_pcOut    = r_pc;
    assign o_instOut  = r_inst;
    assign o_validOut = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= FETCH;
            r_addr        <= RESET_PC;
            r_pc          <= 32'h0;
            r_inst        <= NOP_INST;
            r_valid       <= 1'b0;
            r_holdInst    <= 32'h0;
            r_holdPc      <= 32'h0;
            r_savedTarget <= 32'h0;
        end else begin
            // Downstream took the slot; a refill below overrides this.
            if (r_valid && !i_stall) begin
                r_valid <= 1'b0;
                r_inst  <= NOP_INST;
            end

            case (r_state)
                FETCH: begin
                    if (i_imemAck) begin
                        if (w_redirect) begin
                            r_addr <= w_target;
                        end else if (w_accept) begin
                            r_inst  <= i_imemData;
                            r_pc    <= w_addrNext;
                            r_valid <= 1'b1;
                            r_addr  <= w_addrNext;
                        end else begin
                            r_holdInst <= i_imemData;
                            r_holdPc   <= w_addrNext;
                            r_addr     <= w_addrNext;
                            r_state    <= HOLD;
                        end
                    end else if (w_redirect) begin
                        r_savedTarget <= w_target;
                        r_state       <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The outstanding request must complete before the address can change.
                    if (i_imemAck) begin
                        r_addr  <= w_redirect ? w_target : r_savedTarget;
                        r_state <= FETCH;
                    end else if (w_redirect) begin
                        r_savedTarget <= w_target;
                    end
                end

                HOLD: begin
                    if (w_redirect) begin
                        r_addr  <= w_target;
                        r_state <= FETCH;
                    end else if (!i_stall) begin
                        r_inst  <= r_holdInst;
                        r_pc    <= r_holdPc;
                        r_valid <= 1'b1;
                        r_state <= FETCH;
                    end
                end

                default: r_state <= FETCH;
            endcase

            if (w_redirect) begin
                r_valid <= 1'b0;
                r_inst  <= NOP_INST;
            end
        end
    end

endmodule
